mem_arbiter: RTL and testbench

Shares one single-ported memory bus between the instruction-fetch stage and the load/store stage of the core. Accepts at most one transaction at a time and forwards it to the bus with a registered request/acknowledge handshake. Generates byte strobes from the decoded load/store type and rejects misaligned accesses locally. Bounds every bus transaction with a timeout.

---
 rtl/mem_arbiter_pkg.sv | 26 ++
 rtl/mem_strb_gen.sv | 35 +++
 rtl/mem_arbiter.sv | 172 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the fetch / load-store memory arbiter.
// The mem_type values match func3[1:0] of the decoder's {mem_sign, mem_type} split.
package mem_arbiter_pkg;

   localparam int unsigned STRB_W = 4;
   localparam int unsigned TMO_W  = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      MT_BYTE = 2'b00,
      MT_HALF = 2'b01,
      MT_WORD = 2'b10,
      MT_ILL  = 2'b11
   } mem_type_e;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_LS = 1'b1
   } owner_e;

endpackage

// File: rtl/mem_strb_gen.sv
// Byte-strobe and alignment decode for a 32-bit load/store access.
// Illegal mem_type is reported through the same misaligned flag.
module mem_strb_gen
   import mem_arbiter_pkg::*;
(
   input  logic [1:0]        i_mem_type,
   input  logic [1:0]        i_addr_lo,
   input  logic              i_we,
   output logic [STRB_W-1:0] o_wstrb_c,
   output logic              o_misaligned_c
);

   logic [STRB_W-1:0] w_strb;
   logic              w_mis;

   always_comb begin
      w_strb = '0;
      w_mis  = 1'b0;
      case (i_mem_type)
         MT_BYTE: w_strb = STRB_W'(4'b0001 << i_addr_lo);
         MT_HALF: begin
            w_strb = STRB_W'(4'b0011 << i_addr_lo);
            w_mis  = i_addr_lo[0];
         end
         MT_WORD: begin
            w_strb = 4'b1111;
            w_mis  = |i_addr_lo;
         end
         default: w_mis = 1'b1;
      endcase
      o_misaligned_c = w_mis;
      o_wstrb_c      = (i_we && !w_mis) ? w_strb : '0;
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-ported memory bus between instruction fetch and load/store,
// with local misalignment rejection and a per-transaction ack timeout.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ack,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              ls_rmem,
   input  logic              ls_wmem,
   input  logic [1:0]        ls_mem_type,
   input  logic [ADDR_W-1:0] ls_addr,
   input  logic [DATA_W-1:0] ls_wdata,
   output logic              ls_ack,
   output logic [DATA_W-1:0] ls_rdata,
   output logic              bus_req,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   output logic [STRB_W-1:0] bus_wstrb,
   input  logic [DATA_W-1:0] bus_rdata,
   input  logic              bus_ack,
   input  logic              bus_err,
   output logic              err
);

   state_e            r_state, w_state_nxt;
   owner_e            r_owner;
   logic [TMO_W-1:0]  r_cnt;
   logic [ADDR_W-1:0] r_addr;
   logic              r_we;
   logic [DATA_W-1:0] r_wdata;
   logic [STRB_W-1:0] r_wstrb;
   logic              r_bus_req;
   logic              r_if_ack;
   logic              r_ls_ack;
   logic              r_err;
   logic [DATA_W-1:0] r_rdata;

   logic              w_ls_pend;
   logic              w_pick_ls;
   logic              w_if_mis;
   logic              w_ls_mis;
   logic              w_bad;
   logic              w_timeout;
   logic [STRB_W-1:0] w_ls_strb;
   logic [ADDR_W-1:0] w_lat_addr;
   owner_e            w_ack_owner;
   logic              w_grant;
   logic              w_launch;
   logic              w_enter_resp;
   logic              w_resp_err;
   logic [DATA_W-1:0] w_resp_data;

   // r_owner doubles as last_grant: it always names the most recent grantee
   assign w_ls_pend   = ls_rmem | ls_wmem;
   assign w_pick_ls   = w_ls_pend & (~if_req | (r_owner == OWN_IF));
   assign w_if_mis    = |if_addr[1:0];
   assign w_bad       = w_pick_ls ? w_ls_mis : w_if_mis;
   assign w_timeout   = (r_cnt == TMO_W'(TIMEOUT_CYC - 1));
   assign w_lat_addr  = w_pick_ls ? ls_addr : if_addr;
   assign w_ack_owner = w_grant ? (w_pick_ls ? OWN_LS : OWN_IF) : r_owner;

   mem_strb_gen u_strb_gen (
      .i_mem_type     (ls_mem_type),
      .i_addr_lo      (ls_addr[1:0]),
      .i_we           (ls_wmem),
      .o_wstrb_c      (w_ls_strb),
      .o_misaligned_c (w_ls_mis)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (if_req || w_ls_pend) w_state_nxt = w_bad ? ST_RESP : ST_BUS;
         ST_BUS:  if (bus_ack || w_timeout) w_state_nxt = ST_RESP;
         ST_RESP: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Per-state control strobes; an ack arriving on the timeout cycle takes priority
   always_comb begin
      w_grant      = 1'b0;
      w_launch     = 1'b0;
      w_enter_resp = 1'b0;
      w_resp_err   = 1'b0;
      w_resp_data  = '0;
      case (r_state)
         ST_IDLE: begin
            if (if_req || w_ls_pend) begin
               w_grant      = 1'b1;
               w_launch     = ~w_bad;
               w_enter_resp = w_bad;
               w_resp_err   = 1'b1;
            end
         end
         ST_BUS: begin
            if (bus_ack) begin
               w_enter_resp = 1'b1;
               w_resp_err   = bus_err;
               w_resp_data  = bus_rdata;
            end else if (w_timeout) begin
               w_enter_resp = 1'b1;
               w_resp_err   = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_owner   <= OWN_IF;
         r_cnt     <= '0;
         r_addr    <= '0;
         r_we      <= 1'b0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
         r_bus_req <= 1'b0;
         r_if_ack  <= 1'b0;
         r_ls_ack  <= 1'b0;
         r_err     <= 1'b0;
         r_rdata   <= '0;
      end else begin
         r_if_ack <= 1'b0;
         r_ls_ack <= 1'b0;
         if (w_grant) r_owner <= w_pick_ls ? OWN_LS : OWN_IF;
         if (w_launch) begin
            r_addr    <= w_lat_addr & ~ADDR_W'(3);
            r_we      <= w_pick_ls & ls_wmem;
            r_wdata   <= (w_pick_ls && ls_wmem) ? ls_wdata : '0;
            r_wstrb   <= w_pick_ls ? w_ls_strb : '0;
            r_bus_req <= 1'b1;
            r_cnt     <= '0;
         end else if (r_state == ST_BUS) begin
            r_cnt <= r_cnt + TMO_W'(1);
         end
         if (w_enter_resp) begin
            r_bus_req <= 1'b0;
            r_rdata   <= w_resp_data;
            r_err     <= w_resp_err;
            r_if_ack  <= (w_ack_owner == OWN_IF);
            r_ls_ack  <= (w_ack_owner == OWN_LS);
         end
      end
   end

   assign if_ack    = r_if_ack;
   assign ls_ack    = r_ls_ack;
   assign if_rdata  = r_rdata;
   assign ls_rdata  = r_rdata;
   assign err       = r_err;
   assign bus_req   = r_bus_req;
   assign bus_we    = r_we;
   assign bus_addr  = r_addr;
   assign bus_wdata = r_wdata;
   assign bus_wstrb = r_wstrb;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a reference model queues expected bus
// transactions and responses; a slave model and an ack monitor check them.
module tb_mem_arbiter;

   localparam int TMO = 4;

   typedef struct {
      bit          is_ls;
      bit          rd;
      bit          wr;
      logic [1:0]  mt;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          delay;
      logic [31:0] rdata;
      bit          berr;
   } txn_t;

   typedef struct {
      bit          is_ls;
      logic [31:0] rdata;
      bit          err;
   } resp_t;

   typedef struct {
      logic [31:0] addr;
      bit          we;
      logic [31:0] wdata;
      logic [3:0]  strb;
   } busx_t;

   typedef struct {
      int          delay;
      logic [31:0] rdata;
      bit          berr;
      int          high;
   } plan_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_ack;
   logic [31:0] if_rdata;
   logic        ls_rmem;
   logic        ls_wmem;
   logic [1:0]  ls_mem_type;
   logic [31:0] ls_addr;
   logic [31:0] ls_wdata;
   logic        ls_ack;
   logic [31:0] ls_rdata;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_wstrb;
   logic [31:0] bus_rdata = '0;
   logic        bus_ack = 1'b0;
   logic        bus_err = 1'b0;
   logic        err;

   int n_checks = 0;
   int n_errors = 0;
   bit model_last_ls = 1'b0;

   resp_t exp_resp_q[$];
   busx_t exp_bus_q[$];
   plan_t plan_q[$];

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
      .ls_rmem(ls_rmem), .ls_wmem(ls_wmem), .ls_mem_type(ls_mem_type),
      .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_ack(ls_ack), .ls_rdata(ls_rdata),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_wstrb(bus_wstrb), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
      .bus_err(bus_err), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model: derives the expected bus transfer and response from the access rules
   task automatic expect_txn(input txn_t t, output int lat);
      bit         bad;
      bit         we;
      logic [3:0] strb;
      int         a;
      resp_t      r;
      busx_t      b;
      plan_t      p;
      a    = int'(t.addr[1:0]);
      bad  = 1'b0;
      we   = 1'b0;
      strb = 4'b0000;
      if (!t.is_ls) begin
         bad = (a != 0);
      end else begin
         we = t.wr;
         case (t.mt)
            2'b00: strb = 4'(1 << a);
            2'b01: begin strb = 4'(3 << a); bad = (a % 2) != 0; end
            2'b10: begin strb = 4'hF; bad = (a != 0); end
            default: bad = 1'b1;
         endcase
         if (!we) strb = 4'b0000;
      end
      r.is_ls = t.is_ls;
      if (bad) begin
         r.rdata = 32'h0; r.err = 1'b1; lat = 1;
      end else if (t.delay < TMO) begin
         r.rdata = t.rdata; r.err = t.berr; lat = t.delay + 2;
      end else begin
         r.rdata = 32'h0; r.err = 1'b1; lat = TMO + 1;
      end
      exp_resp_q.push_back(r);
      if (!bad) begin
         b.addr  = {t.addr[31:2], 2'b00};
         b.we    = we;
         b.wdata = t.wdata;
         b.strb  = strb;
         exp_bus_q.push_back(b);
         p.delay = t.delay;
         p.rdata = t.rdata;
         p.berr  = t.berr;
         p.high  = (t.delay < TMO) ? t.delay + 1 : TMO;
         plan_q.push_back(p);
      end
      model_last_ls = t.is_ls;
   endtask

   function automatic txn_t mk(input bit is_ls, input bit rd, input bit wr,
                               input logic [1:0] mt, input logic [31:0] addr,
                               input logic [31:0] wdata, input int delay,
                               input logic [31:0] rdata, input bit berr);
      txn_t t;
      t.is_ls = is_ls; t.rd = rd; t.wr = wr; t.mt = mt; t.addr = addr;
      t.wdata = wdata; t.delay = delay; t.rdata = rdata; t.berr = berr;
      return t;
   endfunction

   function automatic txn_t rand_txn(input bit is_ls);
      txn_t        t;
      logic [31:0] tmp;
      int          sel;
      tmp     = $urandom;
      t.is_ls = is_ls;
      sel     = $urandom_range(0, 2);
      t.rd    = (sel != 1);
      t.wr    = (sel != 0);
      t.mt    = 2'($urandom_range(0, 3));
      t.addr  = {tmp[31:2], ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(0, 3))};
      if (!is_ls && $urandom_range(0, 3) != 0) t.addr[1:0] = 2'b00;
      t.wdata = $urandom;
      sel     = $urandom_range(0, 9);
      t.delay = (sel == 0) ? 1000 : (sel == 1) ? TMO - 1 : $urandom_range(0, TMO - 2);
      t.rdata = $urandom;
      t.berr  = ($urandom_range(0, 7) == 0);
      return t;
   endfunction

   task automatic apply(input txn_t t);
      if (t.is_ls) begin
         ls_rmem = t.rd; ls_wmem = t.wr; ls_mem_type = t.mt;
         ls_addr = t.addr; ls_wdata = t.wdata;
      end else begin
         if_req = 1'b1; if_addr = t.addr;
      end
   endtask

   task automatic release_side(input bit is_ls);
      if (is_ls) begin ls_rmem = 1'b0; ls_wmem = 1'b0; end
      else if_req = 1'b0;
   endtask

   task automatic do_single(input string nm, input txn_t t);
      int lat_exp;
      int lat;
      bit got;
      expect_txn(t, lat_exp);
      @(negedge clk);
      apply(t);
      lat = 0;
      got = 1'b0;
      while (!got && lat < 400) begin
         @(negedge clk);
         lat++;
         got = t.is_ls ? ls_ack : if_ack;
      end
      chk({nm, "_latency"}, 32'(lat), 32'(lat_exp));
      release_side(t.is_ls);
   endtask

   // Both sides held pending; each presents its next request right after its ack
   task automatic contend(input txn_t l0, input txn_t l1, input txn_t i0, input txn_t i1);
      txn_t ll[2];
      txn_t il[2];
      int   li, ii, done, cyc, dummy;
      ll[0] = l0; ll[1] = l1; il[0] = i0; il[1] = i1;
      li = 0; ii = 0;
      while (li < 2 || ii < 2) begin
         if (li < 2 && (ii >= 2 || !model_last_ls)) begin expect_txn(ll[li], dummy); li++; end
         else begin expect_txn(il[ii], dummy); ii++; end
      end
      @(negedge clk);
      apply(ll[0]); apply(il[0]);
      li = 1; ii = 1; done = 0; cyc = 0;
      while (done < 4 && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         if (ls_ack) begin
            done++;
            if (li < 2) begin apply(ll[li]); li++; end else release_side(1'b1);
         end
         if (if_ack) begin
            done++;
            if (ii < 2) begin apply(il[ii]); ii++; end else release_side(1'b0);
         end
      end
      chk("contend_acks", 32'(done), 32'd4);
   endtask

   // Slave model: checks the presented transfer, acks after the planned delay
   initial begin : slave
      int    k;
      bit    act;
      plan_t p;
      busx_t e;
      k = 0; act = 1'b0;
      p.delay = 0; p.rdata = '0; p.berr = 1'b0; p.high = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            k = 0; act = 1'b0; bus_ack = 1'b0;
         end else if (bus_req) begin
            if (!act) begin
               act = 1'b1;
               k   = 0;
               if (exp_bus_q.size() == 0 || plan_q.size() == 0) begin
                  n_checks++; n_errors++;
                  $display("FAIL unexpected_bus_req: addr 0x%0h, no transfer expected", bus_addr);
                  p.delay = 0; p.rdata = '0; p.berr = 1'b0; p.high = 1;
               end else begin
                  e = exp_bus_q.pop_front();
                  p = plan_q.pop_front();
                  chk("bus_addr", bus_addr, e.addr);
                  chk("bus_we", 32'(bus_we), 32'(e.we));
                  chk("bus_wstrb", 32'(bus_wstrb), 32'(e.strb));
                  if (e.we) chk("bus_wdata", bus_wdata, e.wdata);
               end
            end
            if (k == p.delay) begin
               bus_ack = 1'b1; bus_rdata = p.rdata; bus_err = p.berr;
            end else begin
               bus_ack = 1'b0; bus_rdata = $urandom; bus_err = 1'b1;
            end
            k++;
         end else begin
            if (act) chk("bus_req_cycles", 32'(k), 32'(p.high));
            act = 1'b0;
            bus_ack = 1'b0; bus_rdata = $urandom; bus_err = 1'b0;
         end
      end
   end

   // Response monitor: every ack pops and checks the oldest expected response
   initial begin : monitor
      resp_t r;
      forever begin
         @(negedge clk);
         if (rst_n && (if_ack || ls_ack)) begin
            if (if_ack && ls_ack) begin
               n_checks++; n_errors++;
               $display("FAIL dual_ack: if_ack=1 and ls_ack=1 together");
            end else if (exp_resp_q.size() == 0) begin
               n_checks++; n_errors++;
               $display("FAIL stray_ack: if_ack=%0b ls_ack=%0b with no response expected", if_ack, ls_ack);
            end else begin
               r = exp_resp_q.pop_front();
               chk("ack_owner_is_ls", 32'(ls_ack), 32'(r.is_ls));
               chk("rdata", ls_ack ? ls_rdata : if_rdata, r.rdata);
               chk("err", 32'(err), 32'(r.err));
            end
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : driver
      txn_t t;
      int   lat_tmp;
      rst_n = 1'b0;
      if_req = 1'b0; if_addr = '0;
      ls_rmem = 1'b0; ls_wmem = 1'b0; ls_mem_type = 2'b00; ls_addr = '0; ls_wdata = '0;
      #12;
      chk("rst_if_ack", 32'(if_ack), 0);
      chk("rst_ls_ack", 32'(ls_ack), 0);
      chk("rst_bus_req", 32'(bus_req), 0);
      chk("rst_bus_we", 32'(bus_we), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_bus_addr", bus_addr, 0);
      chk("rst_bus_wdata", bus_wdata, 0);
      chk("rst_bus_wstrb", 32'(bus_wstrb), 0);
      chk("rst_if_rdata", if_rdata, 0);
      chk("rst_ls_rdata", ls_rdata, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // contention straight out of reset: LS, IF, LS, IF
      contend(mk(1, 1, 0, 2'b10, 32'h0000_0400, 32'h0, 0, 32'h1111_2222, 0),
              mk(1, 0, 1, 2'b00, 32'h0000_0405, 32'h0000_5500, 2, 32'h3333_4444, 0),
              mk(0, 0, 0, 2'b00, 32'h0000_0100, 32'h0, 1, 32'h5555_6666, 0),
              mk(0, 0, 0, 2'b00, 32'h0000_0104, 32'h0, 0, 32'h7777_8888, 0));

      do_single("fetch_100", mk(0, 0, 0, 2'b00, 32'h0000_0100, 32'h0, 0, 32'hDEAD_BEEF, 0));
      do_single("sb_203", mk(1, 0, 1, 2'b00, 32'h0000_0203, 32'hAB00_0000, 1, 32'h0, 0));
      do_single("sh_202", mk(1, 0, 1, 2'b01, 32'h0000_0202, 32'hCDEF_0000, 0, 32'h0, 0));
      do_single("lw_201", mk(1, 1, 0, 2'b10, 32'h0000_0201, 32'h0, 0, 32'h1234, 0));
      do_single("ill_type", mk(1, 1, 0, 2'b11, 32'h0000_0200, 32'h0, 0, 32'h1234, 0));
      do_single("lh_odd", mk(1, 1, 0, 2'b01, 32'h0000_0301, 32'h0, 0, 32'h1234, 0));
      do_single("fetch_mis", mk(0, 0, 0, 2'b00, 32'h0000_0102, 32'h0, 0, 32'h1234, 0));
      do_single("timeout", mk(1, 1, 0, 2'b10, 32'h0000_0500, 32'h0, 1000, 32'h9999, 0));
      do_single("ack_on_last", mk(1, 1, 0, 2'b10, 32'h0000_0504, 32'h0, TMO - 1, 32'hCAFE_F00D, 0));
      do_single("bus_err", mk(0, 0, 0, 2'b00, 32'h0000_0600, 32'h0, 1, 32'hBAD0_BAD0, 1));
      do_single("rd_wr_both", mk(1, 1, 1, 2'b10, 32'h0000_0704, 32'h0BAD_F00D, 0, 32'h4242, 0));

      // reset while the bus transfer is outstanding
      t = mk(1, 1, 0, 2'b10, 32'h0000_0300, 32'h0, 1000, 32'h0, 0);
      expect_txn(t, lat_tmp);
      @(negedge clk);
      apply(t);
      for (int i = 0; i < 10 && !bus_req; i++) @(negedge clk);
      chk("pre_reset_bus_req", 32'(bus_req), 1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk("reset_drops_bus_req", 32'(bus_req), 0);
      release_side(1'b1);
      exp_resp_q.delete();
      exp_bus_q.delete();
      plan_q.delete();
      model_last_ls = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("post_reset_quiet", 32'({if_ack, ls_ack, bus_req}), 0);
      end
      do_single("post_reset_fetch", mk(0, 0, 0, 2'b00, 32'h0000_0800, 32'h0, 0, 32'h600D_600D, 0));

      for (int n = 0; n < 40; n++) begin
         t = rand_txn($urandom_range(0, 1) == 1);
         do_single("rand", t);
      end
      for (int n = 0; n < 6; n++) begin
         contend(rand_txn(1), rand_txn(1), rand_txn(0), rand_txn(0));
      end

      repeat (5) @(negedge clk);
      chk("resp_q_drained", 32'(exp_resp_q.size()), 0);
      chk("bus_q_drained", 32'(exp_bus_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
